// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that sequences the interval-timer slave's 16-bit register
// accesses for START/STOP/SNAP/STATUS/CLEAR commands, and optionally services
// the timer interrupt in hardware while counting ticks.
module timer_ctrl_master #(
  parameter bit          AUTO_ACK = 1'b1,
  parameter int unsigned TICK_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              cmd_irq_en,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy,
  input  logic              timer_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata
);

  typedef enum logic [3:0] {
    StIdle, StWPl, StWPh, StWCtl, StWStop, StWStat, StWAck,
    StWSnap, StRSnapL, StRSnapH, StRSnapD, StRStat, StRStatD
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         period_hi_q, period_hi_d;
  logic                cont_q, cont_d, ito_q, ito_d;
  logic                shadow_cont_q, shadow_cont_d, shadow_ito_q, shadow_ito_d;
  logic [15:0]         snap_lo_q, snap_lo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                tick_q, tick_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic [2:0]          addr_q, addr_d;
  logic                cs_q, cs_d, wn_q, wn_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                irq_pending;

  assign irq_pending = AUTO_ACK && timer_irq;

  assign cmd_ready     = (state_q == StIdle) && !irq_pending;
  assign busy          = (state_q != StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign tick          = tick_q;
  assign tick_count    = tick_count_q;
  assign av_address    = addr_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wdata_q;

  // Next state, latched command fields, response capture and tick counting.
  always_comb begin
    state_d       = state_q;
    period_hi_d   = period_hi_q;
    cont_d        = cont_q;
    ito_d         = ito_q;
    shadow_cont_d = shadow_cont_q;
    shadow_ito_d  = shadow_ito_q;
    snap_lo_d     = snap_lo_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    tick_count_d  = tick_count_q;
    case (state_q)
      StIdle: begin
        // Interrupt wins; a simultaneous command waits because cmd_ready is low.
        if (irq_pending) begin
          state_d = StWAck;
        end else if (cmd_valid) begin
          period_hi_d = cmd_period[31:16];
          cont_d      = cmd_continuous;
          ito_d       = cmd_irq_en;
          case (cmd_op)
            3'd0:    state_d = StWPl;
            3'd1:    state_d = StWStop;
            3'd2:    state_d = StWSnap;
            3'd3:    state_d = StRStat;
            3'd4:    state_d = StWStat;
            default: state_d = StIdle;
          endcase
        end
      end
      StWPl:  state_d = StWPh;
      StWPh:  state_d = StWCtl;
      StWCtl: begin
        shadow_cont_d = cont_q;
        shadow_ito_d  = ito_q;
        state_d       = StIdle;
      end
      StWStop, StWStat: state_d = StIdle;
      StWAck: begin
        tick_count_d = tick_count_q + TICK_W'(1);
        state_d      = StIdle;
      end
      StWSnap:  state_d = StRSnapL;
      StRSnapL: state_d = StRSnapH;
      StRSnapH: begin
        // Readdata lags address by one cycle: this is the addr-4 low half.
        snap_lo_d = av_readdata;
        state_d   = StRSnapD;
      end
      StRSnapD: begin
        rsp_data_d  = {av_readdata, snap_lo_q};
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StRStat:  state_d = StRStatD;
      StRStatD: begin
        rsp_data_d  = {30'b0, av_readdata[1:0]};
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus and tick outputs decoded from the next state so they register with it.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'h0000;
    tick_d  = 1'b0;
    case (state_d)
      // StWPl is only entered from StIdle on accept, so the live command is used.
      StWPl:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = cmd_period[15:0]; end
      StWPh:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_hi_q; end
      StWCtl:  begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
        wdata_d = {12'b0, 1'b0, 1'b1, cont_q, ito_q};
      end
      StWStop: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
        wdata_d = {12'b0, 1'b1, 1'b0, shadow_cont_q, shadow_ito_q};
      end
      StWStat:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
      StWAck:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; tick_d = 1'b1; end
      StWSnap:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
      StRSnapL: begin cs_d = 1'b1; addr_d = 3'd4; end
      StRSnapH: begin cs_d = 1'b1; addr_d = 3'd5; end
      StRStat:  begin cs_d = 1'b1; addr_d = 3'd0; end
      default:  ;
    endcase
  end

  // State and registered outputs; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      period_hi_q   <= 16'h0000;
      cont_q        <= 1'b0;
      ito_q         <= 1'b0;
      shadow_cont_q <= 1'b0;
      shadow_ito_q  <= 1'b0;
      snap_lo_q     <= 16'h0000;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
      tick_q        <= 1'b0;
      tick_count_q  <= '0;
      addr_q        <= 3'd0;
      cs_q          <= 1'b0;
      wn_q          <= 1'b1;
      wdata_q       <= 16'h0000;
    end else begin
      state_q       <= state_d;
      period_hi_q   <= period_hi_d;
      cont_q        <= cont_d;
      ito_q         <= ito_d;
      shadow_cont_q <= shadow_cont_d;
      shadow_ito_q  <= shadow_ito_d;
      snap_lo_q     <= snap_lo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      tick_q        <= tick_d;
      tick_count_q  <= tick_count_d;
      addr_q        <= addr_d;
      cs_q          <= cs_d;
      wn_q          <= wn_d;
      wdata_q       <= wdata_d;
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: behavioural timer slave, table of commands with
// expected bus cycles and responses, plus interrupt, wrap and reset sequences.
module tb_timer_ctrl_master;

  localparam logic [31:0] SCounter = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_period = 32'h0;
  logic        cmd_continuous = 1'b0;
  logic        cmd_irq_en = 1'b0;
  logic        cmd_ready, rsp_valid, busy, tick, av_cs, av_wn;
  logic [31:0] rsp_data;
  logic [15:0] tick_count, av_wdata;
  logic [2:0]  av_addr;
  logic [15:0] rd = 16'h0;
  logic        timer_irq;

  // Narrow-counter instance sharing all inputs (wrap check).
  logic        cmd_ready_w, rsp_valid_w, busy_w, tick_w, cs_w, wn_w;
  logic [31:0] rsp_data_w;
  logic [1:0]  tick_count_w;
  logic [2:0]  addr_w;
  logic [15:0] wdata_w;

  // AUTO_ACK=0 instance with irq held high and no commands.
  logic        cmd_ready0, rsp_valid0, busy0, tick0, cs0, wn0;
  logic [31:0] rsp_data0;
  logic [15:0] tick_count0, wdata0;
  logic [2:0]  addr0;

  // Slave model state.
  logic        s_to = 1'b0;
  logic        s_run = 1'b0;
  logic [31:0] s_snap = 32'h0;
  logic        to_set = 1'b0;

  int n_checks = 0;
  int n_err = 0;
  int w_mis = 0;
  int cs0_cnt = 0;
  int tick0_cnt = 0;
  int exp_ticks = 0;
  logic [31:0] last_rsp = 32'h0;

  assign timer_irq = s_to;

  always #5 clk = ~clk;

  timer_ctrl_master #(.AUTO_ACK(1'b1), .TICK_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_irq_en(cmd_irq_en), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .timer_irq(timer_irq), .tick(tick), .tick_count(tick_count), .av_address(av_addr),
    .av_chipselect(av_cs), .av_write_n(av_wn), .av_writedata(av_wdata), .av_readdata(rd)
  );

  timer_ctrl_master #(.AUTO_ACK(1'b1), .TICK_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_irq_en(cmd_irq_en), .rsp_valid(rsp_valid_w), .rsp_data(rsp_data_w), .busy(busy_w),
    .timer_irq(timer_irq), .tick(tick_w), .tick_count(tick_count_w), .av_address(addr_w),
    .av_chipselect(cs_w), .av_write_n(wn_w), .av_writedata(wdata_w), .av_readdata(rd)
  );

  timer_ctrl_master #(.AUTO_ACK(1'b0), .TICK_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(1'b0), .cmd_ready(cmd_ready0),
    .cmd_op(3'd0), .cmd_period(32'h0), .cmd_continuous(1'b0),
    .cmd_irq_en(1'b0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
    .timer_irq(1'b1), .tick(tick0), .tick_count(tick_count0), .av_address(addr0),
    .av_chipselect(cs0), .av_write_n(wn0), .av_writedata(wdata0), .av_readdata(16'h0)
  );

  // Timer slave: registered readdata, status clear on addr-0 write, snapshot on addr-4 write.
  always @(posedge clk) begin
    if (to_set) s_to <= 1'b1;
    if (av_cs && !av_wn) begin
      case (av_addr)
        3'd0: s_to <= 1'b0;
        3'd1: begin
          if (av_wdata[2]) s_run <= 1'b1;
          if (av_wdata[3]) s_run <= 1'b0;
        end
        3'd4: s_snap <= SCounter;
        default: ;
      endcase
    end
    case (av_addr)
      3'd0:    rd <= {14'b0, s_run, s_to};
      3'd4:    rd <= s_snap[15:0];
      3'd5:    rd <= s_snap[31:16];
      default: rd <= 16'h0;
    endcase
  end

  // Side monitors for the narrow and AUTO_ACK=0 instances.
  always @(negedge clk) begin
    if ({cmd_ready_w, rsp_valid_w, busy_w, tick_w, cs_w, wn_w, rsp_data_w, addr_w, wdata_w} !==
        {cmd_ready, rsp_valid, busy, tick, av_cs, av_wn, rsp_data, av_addr, av_wdata})
      w_mis <= w_mis + 1;
    if (cs0 || !wn0 || busy0 || !cmd_ready0) cs0_cnt <= cs0_cnt + 1;
    if (tick0 || rsp_valid0) tick0_cnt <= tick0_cnt + 1;
  end

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      period;
    logic             cont;
    logic             ito;
    int               len;
    logic [3:0][20:0] seq;
    logic             has_rsp;
    logic [31:0]      rsp;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [20:0] bus(input logic cs, input logic wn, input logic [2:0] a,
                                      input logic [15:0] d);
    return {cs, wn, a, d};
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] period, input logic cont,
                              input logic ito, input int len, input logic [20:0] s0,
                              input logic [20:0] s1, input logic [20:0] s2, input logic [20:0] s3,
                              input logic has_rsp, input logic [31:0] rsp);
    vec_t v;
    v.op = op; v.period = period; v.cont = cont; v.ito = ito; v.len = len;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3;
    v.has_rsp = has_rsp; v.rsp = rsp;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Write data is only meaningful on write cycles.
  task automatic chk_bus(input string nm, input logic [20:0] e);
    logic [20:0] a, em;
    a  = {av_cs, av_wn, av_addr, av_wn ? 16'h0 : av_wdata};
    em = e[19] ? {e[20:16], 16'h0} : e;
    chk(nm, {11'b0, a}, {11'b0, em});
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!cmd_ready) begin
      chk({nm, " ready timeout"}, 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = v.op; cmd_period = v.period;
    cmd_continuous = v.cont; cmd_irq_en = v.ito;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < v.len; k++) begin
      chk_bus($sformatf("%s bus%0d", nm, k), v.seq[k]);
      chk($sformatf("%s busy%0d", nm, k), 32'(busy), 32'd1);
      chk($sformatf("%s rspv%0d", nm, k), 32'(rsp_valid), 32'd0);
      step();
    end
    chk({nm, " end bus"}, 32'(av_cs), 32'd0);
    chk({nm, " end busy"}, 32'(busy), 32'd0);
    chk({nm, " end ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(v.has_rsp));
    if (v.has_rsp) last_rsp = v.rsp;
    chk({nm, " rsp_data"}, rsp_data, last_rsp);
    step();
    chk({nm, " rsp pulse"}, 32'(rsp_valid), 32'd0);
    chk({nm, " rsp hold"}, rsp_data, last_rsp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] idle_b;
    idle_b = bus(1'b0, 1'b1, 3'd0, 16'h0);
    vecs[0]  = mk(3'd0, 32'h0001_86A0, 1'b1, 1'b1, 3, bus(1,0,3'd2,16'h86A0),
                  bus(1,0,3'd3,16'h0001), bus(1,0,3'd1,16'h0007), idle_b, 1'b0, 32'h0);
    vecs[1]  = mk(3'd1, 32'h0, 1'b0, 1'b0, 1, bus(1,0,3'd1,16'h000B), idle_b, idle_b, idle_b,
                  1'b0, 32'h0);
    vecs[2]  = mk(3'd3, 32'h0, 1'b0, 1'b0, 2, bus(1,1,3'd0,16'h0), idle_b, idle_b, idle_b,
                  1'b1, 32'h0);
    vecs[3]  = mk(3'd0, 32'h0000_0010, 1'b0, 1'b1, 3, bus(1,0,3'd2,16'h0010),
                  bus(1,0,3'd3,16'h0000), bus(1,0,3'd1,16'h0005), idle_b, 1'b0, 32'h0);
    vecs[4]  = mk(3'd2, 32'h0, 1'b0, 1'b0, 4, bus(1,0,3'd4,16'h0), bus(1,1,3'd4,16'h0),
                  bus(1,1,3'd5,16'h0), idle_b, 1'b1, SCounter);
    vecs[5]  = mk(3'd3, 32'h0, 1'b0, 1'b0, 2, bus(1,1,3'd0,16'h0), idle_b, idle_b, idle_b,
                  1'b1, 32'h2);
    vecs[6]  = mk(3'd5, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, idle_b, idle_b, idle_b, idle_b,
                  1'b0, 32'h0);
    vecs[7]  = mk(3'd4, 32'h0, 1'b0, 1'b0, 1, bus(1,0,3'd0,16'h0), idle_b, idle_b, idle_b,
                  1'b0, 32'h0);
    vecs[8]  = mk(3'd1, 32'h0, 1'b1, 1'b1, 1, bus(1,0,3'd1,16'h0009), idle_b, idle_b, idle_b,
                  1'b0, 32'h0);
    vecs[9]  = mk(3'd3, 32'h0, 1'b0, 1'b0, 2, bus(1,1,3'd0,16'h0), idle_b, idle_b, idle_b,
                  1'b1, 32'h0);
    vecs[10] = mk(3'd7, 32'h0, 1'b0, 1'b0, 0, idle_b, idle_b, idle_b, idle_b, 1'b0, 32'h0);
    vecs[11] = mk(3'd0, 32'h0000_0020, 1'b1, 1'b0, 3, bus(1,0,3'd2,16'h0020),
                  bus(1,0,3'd3,16'h0000), bus(1,0,3'd1,16'h0006), idle_b, 1'b0, 32'h0);

    // Reset state.
    step(); step();
    reset_n = 1'b1;
    step();
    chk_bus("reset bus", idle_b);
    chk("reset ready", 32'(cmd_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rspv", 32'(rsp_valid), 32'd0);
    chk("reset rspd", rsp_data, 32'h0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset tcnt", 32'(tick_count), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Interrupt arriving with a pending STATUS: ack first, then STATUS runs.
    to_set = 1'b1;
    step();
    to_set = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd3;
    #1;
    chk("ack ready low", 32'(cmd_ready), 32'd0);
    step();
    chk_bus("ack bus", bus(1,0,3'd0,16'h0));
    chk("ack tick", 32'(tick), 32'd1);
    chk("ack busy", 32'(busy), 32'd1);
    step();
    exp_ticks++;
    chk("ack tick end", 32'(tick), 32'd0);
    chk("ack tcnt", 32'(tick_count), 32'(exp_ticks));
    chk("ack ready back", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk_bus("ack stat rd", bus(1,1,3'd0,16'h0));
    step();
    chk("ack stat busy", 32'(busy), 32'd1);
    chk("ack no retick", 32'(tick), 32'd0);
    step();
    chk("ack stat rspv", 32'(rsp_valid), 32'd1);
    chk("ack stat rspd", rsp_data, 32'h2);
    last_rsp = 32'h2;

    // Further interrupts: narrow counter wraps 3 -> 0.
    for (int i = 0; i < 3; i++) begin
      to_set = 1'b1;
      step();
      to_set = 1'b0;
      step();
      chk($sformatf("irq%0d tick", i), 32'(tick), 32'd1);
      step();
      exp_ticks++;
      chk($sformatf("irq%0d tcnt", i), 32'(tick_count), 32'(exp_ticks));
      chk($sformatf("irq%0d tcnt_w", i), 32'(tick_count_w), 32'(exp_ticks % 4));
      chk($sformatf("irq%0d idle", i), 32'(busy), 32'd0);
    end

    // Reset during W_PH abandons START; no control write follows.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_period = 32'hABCD_1234;
    cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk_bus("rst wpl", bus(1,0,3'd2,16'h1234));
    step();
    chk_bus("rst wph", bus(1,0,3'd3,16'hABCD));
    reset_n = 1'b0;
    #1;
    chk_bus("rst bus", idle_b);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(cmd_ready), 32'd1);
    chk("rst rspd", rsp_data, 32'h0);
    chk("rst tcnt", 32'(tick_count), 32'd0);
    chk("rst tcnt_w", 32'(tick_count_w), 32'd0);
    last_rsp = 32'h0;
    step();
    reset_n = 1'b1;
    step();
    chk("rst no wctl", 32'(av_cs), 32'd0);
    run_vec(vecs[0], "post-rst start");

    // AUTO_ACK=0 instance and narrow-instance agreement.
    chk("noack activity", 32'(cs0_cnt), 32'd0);
    chk("noack tick/rsp", 32'(tick0_cnt), 32'd0);
    chk("noack tcnt", 32'(tick_count0), 32'd0);
    chk("noack outs", {rsp_data0[15:0], wdata0}, 32'h0);
    chk("noack addr", 32'(addr0), 32'd0);
    chk("narrow agree", 32'(w_mis), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
